uart_transmit: RTL

Serial transmitter for the UART peripheral, the counterpart of the existing UART receive path. It accepts bytes from the bus-side register logic into a small FIFO and serialises each one on `tx` as 8N1: one start bit, eight data bits LSB first, one stop bit, with the line idling high. It shares the `clk_div` baud setting with the receiver and raises an optional interrupt when the FIFO drains.

---
 rtl/uart_transmit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// Baud timing comes from the shared clk_div setting, latched per frame.
module uart_transmit #(
   parameter int FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] clk_div,
   input  logic [7:0]  tx_data,
   input  logic        write,
   input  logic        irq_en,
   output logic        tx,
   output logic        busy,
   output logic        full,
   output logic        irq
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   state_t             state_q, state_d;
   logic [31:0]        clk_cnt_q, clk_cnt_d, div_q, div_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shreg_q;
   logic               tx_q, tx_d, irq_q, irq_d;
   logic               push, pop, fifo_empty, bit_done;
   logic [31:0]        div_eff;

   assign fifo_empty = (count_q == '0);
   assign full       = (count_q == (FIFO_AW+1)'(DEPTH));
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign tx         = tx_q;
   assign irq        = irq_q;

   always_comb begin
      push      = write && !full;
      pop       = 1'b0;
      div_eff   = (clk_div < 32'd2) ? 32'd2 : clk_div;
      bit_done  = (clk_cnt_q == div_q - 32'd1);
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + 32'd1;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      irq_d     = irq_q;
      div_d     = div_q;

      case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               tx_d    = 1'b0;
               state_d = START_BIT;
            end
         end
         START_BIT: begin
            if (bit_done) begin
               tx_d      = shreg_q[0];
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP_BIT;
               end else begin
                  tx_d      = shreg_q[bit_idx_q + 3'd1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         STOP_BIT: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               // Chain straight into the next start bit so queued bytes leave no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  tx_d    = 1'b0;
                  state_d = START_BIT;
               end else begin
                  state_d = IDLE;
                  if (irq_en) irq_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            tx_d      = 1'b1;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            irq_d     = 1'b0;
         end
      endcase

      if (pop) div_d = div_eff;
      // Clearing wins over a same-cycle set.
      if (push || !irq_en) irq_d = 1'b0;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
      else if (pop && !push) count_d = count_q - (FIFO_AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= tx_data;
      if (pop)          shreg_q         <= mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         div_q     <= 32'd2;
         tx_q      <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         div_q     <= div_d;
         tx_q      <= tx_d;
         irq_q     <= irq_d;
      end
   end

endmodule
